// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: XLEN and the types used by the data-memory responder.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      MemByte = 2'b00,
      MemHalf = 2'b01,
      MemWord = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_e;

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load alignment: extracts byte/half/word from a memory word and extends it to XLEN.
module dmem_load_align
   import riscv_pkg::*;
(
   input  logic [31:0]     word_i,
   input  logic [1:0]      lane_i,
   input  mem_size_e       size_i,
   input  logic            unsigned_i,
   output logic [XLEN-1:0] data_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        byte_sign;
   logic        half_sign;

   always_comb begin
      shifted   = word_i >> {lane_i, 3'b000};
      byte_v    = shifted[7:0];
      half_v    = shifted[15:0];
      byte_sign = byte_v[7] & ~unsigned_i;
      half_sign = half_v[15] & ~unsigned_i;
      case (size_i)
         MemByte: data_o = {{(XLEN-8){byte_sign}}, byte_v};
         MemHalf: data_o = {{(XLEN-16){half_sign}}, half_v};
         default: data_o = XLEN'(word_i);
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with byte-lane writes,
// extended load data after LATENCY cycles, and misalign/range error flagging.
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   input  logic [1:0]      req_size_i,
   input  logic            req_unsigned_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_err_o
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);
   localparam int unsigned CNT_W = 2;

   logic [31:0] mem_q [MEM_WORDS];

   dmem_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [IDX_W-1:0] word_idx;
   logic [1:0]       lane;
   logic             out_of_range;
   logic             misalign;
   logic             req_err;
   logic             accept;
   logic             mem_we;
   logic [3:0]       byte_en;
   logic [31:0]      wdata_sh;
   logic [XLEN-1:0]  load_data;

   // Address decode, error classification and store lane steering
   always_comb begin
      word_idx     = req_addr_i[2 +: IDX_W];
      lane         = req_addr_i[1:0];
      out_of_range = req_addr_i[XLEN-1:2] >= (XLEN-2)'(MEM_WORDS);
      misalign     = ((req_size_i == MemHalf) && lane[0])
                  || ((req_size_i == MemWord) && (lane != 2'd0))
                  || (req_size_i == 2'b11);
      req_err      = misalign || out_of_range;
      accept       = req_valid_i && req_ready_o;
      mem_we       = accept && req_we_i && !req_err;
      wdata_sh     = req_wdata_i[31:0] << {lane, 3'b000};
      case (req_size_i)
         MemByte: byte_en = 4'b0001 << lane;
         MemHalf: byte_en = 4'b0011 << lane;
         MemWord: byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   // Array is not reset; stores commit on the acceptance edge
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_we && byte_en[b]) begin
            mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   dmem_load_align u_load_align (
      .word_i     (mem_q[word_idx]),
      .lane_i     (lane),
      .size_i     (mem_size_e'(req_size_i)),
      .unsigned_i (req_unsigned_i),
      .data_o     (load_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rdata_d = (req_we_i || req_err) ? '0 : load_data;
               err_d   = req_err;
               if (LATENCY <= 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Ready is held low during reset so nothing is accepted or written then
   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=1 and LATENCY=3 instances checked against a byte-level memory model.
module tb_dmem_responder;
   import riscv_pkg::*;

   localparam int unsigned MW     = 1024;
   localparam int unsigned MODEL_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_uns = 1'b0;
   logic        rsp_ready = 1'b0;

   logic        rdy1, rdy3, vld1, vld3, err1, err3;
   logic [31:0] rd1, rd3;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic [31:0] mdl [2][MODEL_W];

   assign req_ready = sel ? rdy3 : rdy1;
   assign rsp_valid = sel ? vld3 : vld1;
   assign rsp_err   = sel ? err3 : err1;
   assign rsp_rdata = sel ? rd3  : rd1;

   dmem_responder #(.MEM_WORDS(MW), .LATENCY(1)) u_dut1 (
      .clk_i (clk), .rst_i (rst),
      .req_valid_i (req_valid && !sel), .req_ready_o (rdy1),
      .req_we_i (req_we), .req_addr_i (req_addr), .req_wdata_i (req_wdata),
      .req_size_i (req_size), .req_unsigned_i (req_uns),
      .rsp_valid_o (vld1), .rsp_ready_i (rsp_ready && !sel),
      .rsp_rdata_o (rd1), .rsp_err_o (err1)
   );

   dmem_responder #(.MEM_WORDS(MW), .LATENCY(3)) u_dut3 (
      .clk_i (clk), .rst_i (rst),
      .req_valid_i (req_valid && sel), .req_ready_o (rdy3),
      .req_we_i (req_we), .req_addr_i (req_addr), .req_wdata_i (req_wdata),
      .req_size_i (req_size), .req_unsigned_i (req_uns),
      .rsp_valid_o (vld3), .rsp_ready_i (rsp_ready && sel),
      .rsp_rdata_o (rd3), .rsp_err_o (err3)
   );

   // Reference: memory as bytes, access rules in plain arithmetic
   function automatic void ref_access(input int s, input bit we, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [1:0] sz, input bit u,
                                      output logic [31:0] rd, output bit er);
      int nb;
      int w;
      int off;
      logic [31:0] v;
      logic [31:0] mask;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      er = (sz == 2'd3) || ((a % nb) != 0) || ((a / 4) >= MW);
      rd = '0;
      if (er) return;
      w   = int'(a / 4);
      off = int'(a % 4);
      if (we) begin
         for (int b = 0; b < nb; b++) mdl[s][w][8*(off+b) +: 8] = wd[8*b +: 8];
         return;
      end
      v = mdl[s][w] >> (8 * off);
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         v = v & mask;
         if (!u && v[8*nb-1]) v = v | ~mask;
      end
      rd = v;
   endfunction

   // One full request/response transaction on the selected instance
   task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit uns, input int hold,
                         output logic [31:0] rdata, output logic err);
      int lows;
      int lat;
      lat = sel ? 3 : 1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL req_ready_idle: got %b want 1", req_ready);
      end
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_uns = uns;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      lows = 0;
      while (rsp_valid !== 1'b1 && lows < 20) begin
         lows++;
         @(negedge clk);
      end
      checks++;
      if (lows != lat - 1) begin
         failures++;
         $display("FAIL latency: got %0d low cycles want %0d (sel=%0d)", lows, lat - 1, sel);
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      for (int i = 0; i < hold; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_hold: valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                     rsp_valid, rsp_rdata, rsp_err, req_ready, rdata, err);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL after_handshake: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (vld1 !== 1'b0 || rd1 !== 32'h0 || err1 !== 1'b0 || rdy1 !== 1'b0 ||
          vld3 !== 1'b0 || rd3 !== 32'h0 || err3 !== 1'b0 || rdy3 !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: vld=%b%b rd=%h/%h err=%b%b rdy=%b%b want all 0",
                  vld1, vld3, rd1, rd3, err1, err3, rdy1, rdy3);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset: got %b%b want 11", rdy1, rdy3);
      end
   endtask

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      bit          uns;
      int          hold;
      logic [31:0] exp_d;
      bit          exp_e;
   } op_t;

   task automatic test_directed();
      op_t ops[14];
      logic [31:0] rd, md;
      logic er;
      bit me;
      ops = '{
         '{1'b1, 32'h10,   32'hDEADBEEF, 2'd2, 1'b0, 0, 32'h0,        1'b0},
         '{1'b0, 32'h10,   32'h0,        2'd2, 1'b0, 5, 32'hDEADBEEF, 1'b0},
         '{1'b1, 32'h13,   32'h12345680, 2'd0, 1'b0, 0, 32'h0,        1'b0},
         '{1'b0, 32'h13,   32'h0,        2'd0, 1'b0, 0, 32'hFFFFFF80, 1'b0},
         '{1'b0, 32'h13,   32'h0,        2'd0, 1'b1, 1, 32'h00000080, 1'b0},
         '{1'b0, 32'h10,   32'h0,        2'd2, 1'b0, 0, 32'h80ADBEEF, 1'b0},
         '{1'b1, 32'h12,   32'hABCD8001, 2'd1, 1'b0, 0, 32'h0,        1'b0},
         '{1'b0, 32'h12,   32'h0,        2'd1, 1'b0, 0, 32'hFFFF8001, 1'b0},
         '{1'b0, 32'h12,   32'h0,        2'd1, 1'b1, 0, 32'h00008001, 1'b0},
         '{1'b0, 32'h11,   32'h0,        2'd1, 1'b0, 2, 32'h0,        1'b1},
         '{1'b1, 32'h12,   32'h12345678, 2'd2, 1'b0, 0, 32'h0,        1'b1},
         '{1'b0, 32'h10,   32'h0,        2'd2, 1'b0, 0, 32'h8001BEEF, 1'b0},
         '{1'b0, 32'h10,   32'h0,        2'd3, 1'b0, 0, 32'h0,        1'b1},
         '{1'b0, 32'h1000, 32'h0,        2'd2, 1'b0, 0, 32'h0,        1'b1}
      };
      sel = 1'b0;
      foreach (ops[i]) begin
         access(ops[i].we, ops[i].addr, ops[i].wdata, ops[i].size, ops[i].uns, ops[i].hold, rd, er);
         ref_access(0, ops[i].we, ops[i].addr, ops[i].wdata, ops[i].size, ops[i].uns, md, me);
         checks++;
         if (rd !== ops[i].exp_d || er !== ops[i].exp_e) begin
            failures++;
            $display("FAIL directed_%0d: got rdata=%h err=%b want rdata=%h err=%b",
                     i, rd, er, ops[i].exp_d, ops[i].exp_e);
         end
      end
   endtask

   task automatic test_random(input bit s);
      logic [31:0] rd, md, a;
      logic er;
      bit me;
      bit we;
      logic [1:0] sz;
      bit u;
      sel = s;
      for (int w = 0; w < int'(MODEL_W); w++) begin
         a = 32'(4 * w);
         md = $urandom;
         access(1'b1, a, md, 2'd2, 1'b0, 0, rd, er);
         ref_access(int'(s), 1'b1, a, md, 2'd2, 1'b0, md, me);
      end
      for (int n = 0; n < 70; n++) begin
         if ($urandom_range(0, 7) == 0) a = 32'(MW * 4) + 32'($urandom_range(0, 63));
         else a = 32'($urandom_range(0, 63));
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom_range(0, 1));
         md = $urandom;
         access(we, a, md, sz, u, $urandom_range(0, 2), rd, er);
         ref_access(int'(s), we, a, md, sz, u, md, me);
         checks++;
         if (rd !== md || er !== me) begin
            failures++;
            $display("FAIL random_op sel=%0d we=%b addr=%h size=%0d uns=%b: got %h/%b want %h/%b",
                     s, we, a, sz, u, rd, er, md, me);
         end
      end
      for (int w = 0; w < int'(MODEL_W); w++) begin
         a = 32'(4 * w);
         access(1'b0, a, 32'h0, 2'd2, 1'b0, 0, rd, er);
         ref_access(int'(s), 1'b0, a, 32'h0, 2'd2, 1'b0, md, me);
         checks++;
         if (rd !== md || er !== 1'b0) begin
            failures++;
            $display("FAIL readback sel=%0d word=%0d: got %h/%b want %h/0", s, w, rd, er, md);
         end
      end
   endtask

   task automatic test_lat3_range();
      logic [31:0] rd;
      logic er;
      sel = 1'b1;
      access(1'b0, 32'(MW * 4), 32'h0, 2'd2, 1'b0, 0, rd, er);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         failures++;
         $display("FAIL lat3_out_of_range: got %h/%b want 00000000/1", rd, er);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd, md;
      logic er;
      bit me;
      bit seen;
      sel = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      req_size = 2'd2; req_uns = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      ref_access(1, 1'b1, 32'h20, 32'hCAFEF00D, 2'd2, 1'b0, md, me);
      rst = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_in_reset: got %b want 0", req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL after_mid_reset: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
      end
      seen = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL dropped_response: got valid=1 after reset want 0");
      end
      access(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, rd, er);
      ref_access(1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, md, me);
      checks++;
      if (rd !== md || rd !== 32'hCAFEF00D || er !== 1'b0) begin
         failures++;
         $display("FAIL store_survives_reset: got %h/%b want cafef00d/0", rd, er);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_directed();
      test_lat3_range();
      test_reset_in_wait();
      test_random(1'b0);
      test_random(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
